unidade_funcional_pipe: RTL and testbench
=========================================

// Module: unidade_funcional_pipe
// PURPOSE
//  Parametrised, pipelined Tomasulo functional unit; successor of the fixed 3-cycle 16-bit add/sub FU.
//  Accepts one op per cycle from the reservation stations (valid/ready), executes over LATENCY stages,
//  presents the result, destination and tag on the CDB; holds it until cdb_grant (back-pressure).
//  Adds logic/shift/compare ops, tag/dest width params and a synchronous flush.
// PARAMETERS
//  WIDTH    16  operand/result width (>=8)
//  LATENCY  3   cycles from issue acceptance to cdb_valid (1..8)
//  DEST_W   3   destination register index width
//  TAG_W    4   reservation-station tag (Qi) width
// PORTS
//  clock        in   1        rising-edge clock
//  reset_n      in   1        asynchronous active-low reset
//  issue_valid  in   1        RS presents an op
//  issue_ready  out  1        FU accepts op this cycle (combinational)
//  opcode       in   3        operation, see BEHAVIOUR
//  vj, vk       in   WIDTH    operands
//  dest_in      in   DEST_W   destination register
//  qi_in        in   TAG_W    producing RS tag
//  flush        in   1        sync kill of all in-flight ops
//  cdb_valid    out  1        result present
//  cdb_grant    in   1        CDB arbiter takes result this cycle
//  cdb_value    out  WIDTH    result
//  cdb_dest     out  DEST_W   destination register
//  cdb_tag      out  TAG_W    tag of producing RS
//  busy         out  1        any stage holds a valid op
// BEHAVIOUR
//  Reset (reset_n=0, async): all stage valid bits, cdb_valid, busy = 0; cdb_value/dest/tag = 0.
//  Pipeline: LATENCY stages, each {valid, value, dest, tag}; last stage drives cdb_*.
//  advance = !cdb_valid | cdb_grant; all stages shift together when advance=1, hold otherwise.
//  issue_ready = advance & !flush; op accepted on edge where issue_valid & issue_ready.
//  Accepted at edge t -> cdb_valid=1 after edge t+LATENCY-1 (LATENCY=1: visible right after accept edge),
//  provided no stall; each stall cycle adds one cycle. Throughput 1 op/cycle with cdb_grant held 1.
//  Bubble enters stage 0 when advance=1 and no accept.
//  Result computed at accept, carried through stages (WIDTH bits, wrap-around modulo 2^WIDTH):
//   000 ADD vj+vk | 001 SUB vj-vk | 010 AND | 011 OR | 100 XOR
//   101 SLT signed (vj<vk) ? 1 : 0 | 110 SLL vj << vk[$clog2(WIDTH)-1:0]
//   111 MUL (low WIDTH bits of vj*vk) with UF_MUL_EN; else ADD (legacy default).
//  cdb_valid & !cdb_grant: cdb_* stable, pipeline frozen, issue_ready=0.
//  cdb_grant while cdb_valid=0: ignored.
//  flush=1: at next edge all valid bits (incl. output) cleared; same-cycle issue rejected
//   (issue_ready=0); same-cycle grant is still a valid handshake for the presented result.
//  busy = OR of all stage valid bits (registered state only).
//  Reset mid-operation: all in-flight ops discarded, no CDB pulse after release.
// CONFIGURATION
//  UF_MUL_EN defined: opcode 111 = multiply, low WIDTH bits; multiplier result still
//   follows LATENCY (no extra stage). Undefined: no multiplier instantiated, 111 = ADD.
// STRUCTURE
//  Package uf_pkg: opcode localparams (UF_OP_ADD..UF_OP_MUL), uf_op_t 3-bit typedef,
//   stage struct typedef shared with RS/CDB arbiter.
//  Sub-module uf_alu: purely combinational WIDTH-param op decoder/ALU; pipe/handshake in top.
// TESTING
//  Reset: hold reset_n=0 mid-flight with 2 ops in pipe -> after release cdb_valid=0, busy=0, no pulse.
//  Latency: LATENCY=3, grant=1, issue ADD 5+7 dest=2 tag=9 -> cdb_valid after 3rd edge, value=12, dest=2, tag=9.
//  Ops/wrap: SUB 0x0003-0x0005 -> 0xFFFE; SLT 0xFFFF,0x0001 -> 1; SLL 1,vk=0x13 -> 0x0008; 111 w/o macro 2,3 -> 5.
//  Back-pressure: 4 back-to-back issues, grant=0 for 5 cycles -> issue_ready=0, first result held stable,
//   then grant=1 -> 4 results in order on consecutive cycles, none lost or duplicated.
//  Flush: 3 ops in flight + issue_valid and flush same cycle -> next cycle busy=0, cdb_valid=0, issue not taken.
//  UF_MUL_EN build: MUL 0x0100*0x0101 -> 0x0100 (low 16 bits); throughput 1/cycle unchanged.

Source files
------------

// File: rtl/uf_pkg.sv
// Shared definitions for the pipelined Tomasulo functional unit: opcode encodings,
// default widths and the per-stage record also used by the RS and CDB arbiter.
package uf_pkg;

  typedef logic [2:0] uf_op_t;

  localparam uf_op_t UF_OP_ADD = 3'b000;
  localparam uf_op_t UF_OP_SUB = 3'b001;
  localparam uf_op_t UF_OP_AND = 3'b010;
  localparam uf_op_t UF_OP_OR  = 3'b011;
  localparam uf_op_t UF_OP_XOR = 3'b100;
  localparam uf_op_t UF_OP_SLT = 3'b101;
  localparam uf_op_t UF_OP_SLL = 3'b110;
  localparam uf_op_t UF_OP_MUL = 3'b111;

  localparam int UF_WIDTH  = 16;
  localparam int UF_DEST_W = 3;
  localparam int UF_TAG_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [UF_WIDTH-1:0]  value;
    logic [UF_DEST_W-1:0] dest;
    logic [UF_TAG_W-1:0]  tag;
  } uf_stage_t;

endpackage

// File: rtl/uf_alu.sv
// Combinational ALU for the functional unit; all results wrap modulo 2^WIDTH.
// Build macro UF_MUL_EN turns opcode 111 into a multiply, otherwise it aliases ADD.
module uf_alu
  import uf_pkg::*;
#(
  parameter int WIDTH = UF_WIDTH
) (
  input  uf_op_t           opcode,
  input  logic [WIDTH-1:0] vj,
  input  logic [WIDTH-1:0] vk,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = vk[SH_W-1:0];

  always_comb begin
    result = '0;
    case (opcode)
      UF_OP_ADD: result = vj + vk;
      UF_OP_SUB: result = vj - vk;
      UF_OP_AND: result = vj & vk;
      UF_OP_OR:  result = vj | vk;
      UF_OP_XOR: result = vj ^ vk;
      UF_OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(vj) < $signed(vk))};
      UF_OP_SLL: result = vj << shamt;
`ifdef UF_MUL_EN
      UF_OP_MUL: result = vj * vk;
`else
      UF_OP_MUL: result = vj + vk;
`endif
      default:   result = vj + vk;
    endcase
  end

endmodule

// File: rtl/unidade_funcional_pipe.sv
// Pipelined Tomasulo functional unit: issue handshake, LATENCY-deep result pipe and CDB
// back-pressure. Build macro UF_MUL_EN enables the multiplier in uf_alu.
module unidade_funcional_pipe
  import uf_pkg::*;
#(
  parameter int WIDTH   = UF_WIDTH,
  parameter int LATENCY = 3,
  parameter int DEST_W  = UF_DEST_W,
  parameter int TAG_W   = UF_TAG_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  uf_op_t            opcode,
  input  logic [WIDTH-1:0]  vj,
  input  logic [WIDTH-1:0]  vk,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [TAG_W-1:0]  qi_in,
  input  logic              flush,
  output logic              cdb_valid,
  input  logic              cdb_grant,
  output logic [WIDTH-1:0]  cdb_value,
  output logic [DEST_W-1:0] cdb_dest,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              busy
);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  value;
    logic [DEST_W-1:0] dest;
    logic [TAG_W-1:0]  tag;
  } pipe_stage_t;

  pipe_stage_t [LATENCY-1:0] stage_q;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] alu_result;

  uf_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (opcode),
    .vj     (vj),
    .vk     (vk),
    .result (alu_result)
  );

  // The whole pipe moves as one unit; it only freezes while an ungranted result sits on the CDB.
  assign advance     = !stage_q[LATENCY-1].valid || cdb_grant;
  assign issue_ready = advance && !flush;
  assign accept      = issue_valid && issue_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i].valid <= 1'b0;
    end else if (advance) begin
      stage_q[0].valid <= accept;
      if (accept) begin
        stage_q[0].value <= alu_result;
        stage_q[0].dest  <= dest_in;
        stage_q[0].tag   <= qi_in;
      end
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign cdb_valid = stage_q[LATENCY-1].valid;
  assign cdb_value = stage_q[LATENCY-1].value;
  assign cdb_dest  = stage_q[LATENCY-1].dest;
  assign cdb_tag   = stage_q[LATENCY-1].tag;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | stage_q[i].valid;
  end

endmodule

// File: tb/tb_unidade_funcional_pipe.sv
// Scoreboard bench for unidade_funcional_pipe: directed ops push hand-computed results,
// a negedge monitor pops and compares on every CDB handshake.
module tb_unidade_funcional_pipe;
  import uf_pkg::*;

  localparam int WIDTH = 16;
  localparam int LAT   = 3;
  localparam int DW    = 3;
  localparam int TW    = 4;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic [DW-1:0]    dest;
    logic [TW-1:0]    tag;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  uf_op_t           opcode = UF_OP_ADD;
  logic [WIDTH-1:0] vj = '0;
  logic [WIDTH-1:0] vk = '0;
  logic [DW-1:0]    dest_in = '0;
  logic [TW-1:0]    qi_in = '0;
  logic             flush = 1'b0;
  logic             cdb_valid;
  logic             cdb_grant = 1'b1;
  logic [WIDTH-1:0] cdb_value;
  logic [DW-1:0]    cdb_dest;
  logic [TW-1:0]    cdb_tag;
  logic             busy;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   pop_count   = 0;

  unidade_funcional_pipe #(.WIDTH(WIDTH), .LATENCY(LAT), .DEST_W(DW), .TAG_W(TW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .vj          (vj),
    .vk          (vk),
    .dest_in     (dest_in),
    .qi_in       (qi_in),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_grant   (cdb_grant),
    .cdb_value   (cdb_value),
    .cdb_dest    (cdb_dest),
    .cdb_tag     (cdb_tag),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  function automatic void check_output(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endfunction

  // Monitor: every granted CDB result must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && cdb_valid && cdb_grant) begin
      if (sb.size() == 0) begin
        check_output("cdb_unexpected_result", 32'(cdb_value), 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("cdb_value", 32'(cdb_value), 32'(e.value));
        check_output("cdb_dest", 32'(cdb_dest), 32'(e.dest));
        check_output("cdb_tag", 32'(cdb_tag), 32'(e.tag));
        pop_count++;
      end
    end
  end

  // Presents one op and returns one tick after the edge that accepted it; leaves issue_valid high.
  task automatic apply_stimulus(input uf_op_t op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [DW-1:0] d,
                                input logic [TW-1:0] t, input logic [WIDTH-1:0] exp_value);
    bit   taken = 0;
    exp_t e;
    opcode = op; vj = a; vk = b; dest_in = d; qi_in = t;
    issue_valid = 1'b1;
    for (int n = 0; n < 50 && !taken; n++) begin
      @(negedge clock);
      if (issue_ready) begin
        e.value = exp_value; e.dest = d; e.tag = t;
        sb.push_back(e);
        taken = 1;
      end
      @(posedge clock);
      #1;
    end
    if (!taken) check_output("issue_accept_timeout", 32'(taken), 32'd1);
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles && sb.size() != 0; n++) @(posedge clock);
    #1;
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   lat_edges;
    time  t0;
    bit   seen_valid;

    // Reset values
    #1;
    check_output("reset_cdb_valid", 32'(cdb_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_cdb_fields", {cdb_value, 9'(cdb_dest), 7'(cdb_tag)}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check_output("idle_issue_ready", 32'(issue_ready), 32'd1);

    // Latency: ADD 5+7
    apply_stimulus(UF_OP_ADD, 16'd5, 16'd7, 3'd2, 4'd9, 16'd12);
    issue_valid = 1'b0;
    lat_edges = 0;
    while (!cdb_valid && lat_edges < 20) begin
      @(posedge clock); #1;
      lat_edges++;
    end
    check_output("latency_edges_after_accept", 32'(lat_edges), 32'(LAT - 1));
    drain(20);

    // Every opcode, back to back; one op per cycle
    t0 = $time;
    apply_stimulus(UF_OP_SUB, 16'h0003, 16'h0005, 3'd1, 4'd1, 16'hFFFE);
    apply_stimulus(UF_OP_SLT, 16'hFFFF, 16'h0001, 3'd2, 4'd2, 16'h0001);
    apply_stimulus(UF_OP_SLT, 16'h0001, 16'hFFFF, 3'd3, 4'd3, 16'h0000);
    apply_stimulus(UF_OP_SLL, 16'h0001, 16'h0013, 3'd4, 4'd4, 16'h0008);
    apply_stimulus(UF_OP_AND, 16'hF0F0, 16'h0FF0, 3'd5, 4'd5, 16'h00F0);
    apply_stimulus(UF_OP_OR,  16'hF0F0, 16'h0FF0, 3'd6, 4'd6, 16'hFFF0);
    apply_stimulus(UF_OP_XOR, 16'hF0F0, 16'h0FF0, 3'd7, 4'd7, 16'hFF00);
    apply_stimulus(UF_OP_ADD, 16'hFFFF, 16'h0002, 3'd0, 4'd8, 16'h0001);
`ifdef UF_MUL_EN
    apply_stimulus(UF_OP_MUL, 16'h0002, 16'h0003, 3'd1, 4'd10, 16'h0006);
    apply_stimulus(UF_OP_MUL, 16'h0100, 16'h0101, 3'd2, 4'd11, 16'h0100);
`else
    apply_stimulus(UF_OP_MUL, 16'h0002, 16'h0003, 3'd1, 4'd10, 16'h0005);
    apply_stimulus(UF_OP_MUL, 16'h0100, 16'h0101, 3'd2, 4'd11, 16'h0201);
`endif
    check_output("throughput_cycles", 32'(($time - t0) / 10), 32'd10);
    issue_valid = 1'b0;
    drain(20);

    // Back-pressure: grant low for 5 cycles while 4 ops are issued
    cdb_grant = 1'b0;
    fork
      begin
        apply_stimulus(UF_OP_ADD, 16'h0010, 16'h0020, 3'd1, 4'd1, 16'h0030);
        apply_stimulus(UF_OP_SUB, 16'h0050, 16'h0008, 3'd2, 4'd2, 16'h0048);
        apply_stimulus(UF_OP_XOR, 16'hAAAA, 16'h5555, 3'd3, 4'd3, 16'hFFFF);
        apply_stimulus(UF_OP_OR,  16'h1200, 16'h0034, 3'd4, 4'd4, 16'h1234);
        issue_valid = 1'b0;
      end
      begin
        int base;
        for (int n = 0; n < 20 && !cdb_valid; n++) begin
          @(posedge clock); #1;
        end
        check_output("stall_result_arrives", 32'(cdb_valid), 32'd1);
        for (int n = 0; n < 5; n++) begin
          @(negedge clock);
          check_output("stall_issue_ready", 32'(issue_ready), 32'd0);
          check_output("stall_held_result", {cdb_value, 9'(cdb_dest), 7'(cdb_tag)},
                       {16'h0030, 9'd1, 7'd1});
        end
        @(posedge clock); #1;
        base = pop_count;
        cdb_grant = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_output("stall_release_consecutive", 32'(pop_count - base), 32'd4);
      end
    join
    drain(20);

    // Flush with 3 ops in flight and a same-cycle issue attempt
    apply_stimulus(UF_OP_ADD, 16'd1, 16'd1, 3'd1, 4'd1, 16'd2);
    apply_stimulus(UF_OP_ADD, 16'd2, 16'd2, 3'd2, 4'd2, 16'd4);
    apply_stimulus(UF_OP_ADD, 16'd3, 16'd3, 3'd3, 4'd3, 16'd6);
    opcode = UF_OP_ADD; vj = 16'd4; vk = 16'd4; dest_in = 3'd4; qi_in = 4'd4;
    flush = 1'b1;
    @(negedge clock);
    check_output("flush_issue_ready", 32'(issue_ready), 32'd0);
    check_output("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    issue_valid = 1'b0;
    check_output("flush_busy_after", 32'(busy), 32'd0);
    check_output("flush_cdb_valid_after", 32'(cdb_valid), 32'd0);
    check_output("flush_dropped_count", 32'(sb.size()), 32'd2);
    sb.delete();
    seen_valid = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (cdb_valid || busy) seen_valid = 1;
    end
    check_output("flush_no_late_result", 32'(seen_valid), 32'd0);

    // Reset mid-flight with two ops in the pipe
    apply_stimulus(UF_OP_ADD, 16'd9, 16'd9, 3'd5, 4'd5, 16'd18);
    apply_stimulus(UF_OP_SUB, 16'd9, 16'd1, 3'd6, 4'd6, 16'd8);
    issue_valid = 1'b0;
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    sb.delete();
    #2 reset_n = 1'b1;
    check_output("post_reset_cdb_valid", 32'(cdb_valid), 32'd0);
    seen_valid = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (cdb_valid || busy) seen_valid = 1;
    end
    check_output("post_reset_no_pulse", 32'(seen_valid), 32'd0);

    // Still functional after reset
    apply_stimulus(UF_OP_SUB, 16'h0000, 16'h0001, 3'd7, 4'd15, 16'hFFFF);
    issue_valid = 1'b0;
    drain(20);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
